// File: rtl/rs_encoder_stream.sv
// Streaming systematic Reed-Solomon encoder over GF(2^M), SYM symbols per beat.
// Message beats pass through unchanged; P parity symbols follow unless bypassed.
module rs_encoder_stream #(
    parameter int             M         = 4,
    parameter int             SYM       = 2,
    parameter int             K         = 10,
    parameter int             P         = 4,
    parameter logic [M:0]     PRIM_POLY = 5'h13,
    parameter logic [P*M-1:0] GEN_POLY  = 16'hDC87
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM*M-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             enc_en,
    output logic [SYM*M-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam int W  = SYM * M;
    localparam int KB = K / SYM;
    localparam int PB = P / SYM;
    localparam int NB = (KB > PB) ? KB : PB;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(KB - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PB - 1);

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PAR
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             mode;
    logic [P*M-1:0]   par;
    logic [P*M-1:0]   par_next;
    logic [W-1:0]     din;
    logic             load;
    logic             accept;
    logic             first_beat;
    logic             cur_mode;
    logic             msg_last;
    logic             par_last;

    // Constant-operand GF(2^M) multiply, shift-and-add with reduction.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int j = 0; j < M; j++) begin
            if (b[j]) acc = acc ^ sh;
            if (sh[M-1]) sh = (sh << 1) ^ PRIM_POLY[M-1:0];
            else         sh = sh << 1;
        end
        return acc;
    endfunction

    assign din        = in_valid ? in_data : '0;
    assign load       = !out_valid || out_ready;
    assign in_ready   = (state != PAR) && load;
    assign accept     = in_valid && in_ready;
    assign first_beat = (state == IDLE);
    assign cur_mode   = first_beat ? enc_en : mode;
    assign msg_last   = (cnt == K_LAST);
    assign par_last   = (cnt == P_LAST);
    assign busy       = (state != IDLE) || out_valid;

    // Parity LFSR advanced by SYM serial steps, earliest symbol first.
    always_comb begin
        logic [M-1:0]   sym;
        logic [M-1:0]   fb;
        logic [P*M-1:0] t;
        sym = '0;
        fb  = '0;
        t   = par;
        for (int s = 0; s < SYM; s++) begin
            sym = din[(SYM-1-s)*M +: M];
            fb  = sym ^ t[(P-1)*M +: M];
            for (int i = P - 1; i > 0; i--) begin
                t[i*M +: M] = t[(i-1)*M +: M] ^ gf_mul(GEN_POLY[i*M +: M], fb);
            end
            t[0 +: M] = gf_mul(GEN_POLY[0 +: M], fb);
        end
        par_next = t;
    end

    // Frame FSM, parity register and the single-entry output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b1;
            par       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            unique case (state)
                IDLE, MSG: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_data  <= din;
                        out_first <= first_beat;
                        out_last  <= msg_last && !cur_mode;
                        mode      <= cur_mode;
                        if (cur_mode) par <= par_next;
                        if (msg_last) begin
                            cnt   <= '0;
                            state <= cur_mode ? PAR : IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= MSG;
                        end
                    end else begin
                        out_valid <= 1'b0;
                        out_first <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                PAR: begin
                    out_valid <= 1'b1;
                    out_data  <= par[P*M-1 -: W];
                    out_first <= 1'b0;
                    out_last  <= par_last;
                    if (par_last) begin
                        par   <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        par <= par << W;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Directed bench for rs_encoder_stream with an expected-beat queue.
// Parity is derived by polynomial long division of m(x)*x^P by g(x).
module tb_rs_encoder_stream;

    localparam int KB = 5;
    localparam int PB = 2;

    typedef logic [7:0] frame_t [KB];
    typedef logic [7:0] par_t [PB];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       enc_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    logic       out_last;
    logic       busy;

    logic [9:0] q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       bp_mode = 1'b0;
    logic       window = 1'b0;
    int         irlow = 0;
    int         nxfer = 0;
    int         firstc = 0;
    int         lastc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] held = '0;

    rs_encoder_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc_en    (enc_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: always 1, or the 1,0,0,1 pattern under backpressure.
    initial begin
        int idx;
        logic [3:0] pat;
        idx = 0;
        pat = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = pat[3 - (idx % 4)];
                idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [7:0] poly;
        p = '0;
        poly = 8'h13;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (8'(a) << i);
        for (int i = 7; i >= 4; i--)
            if (p[i]) p = p ^ (poly << (i - 4));
        return p[3:0];
    endfunction

    task automatic encode_ref(input frame_t f, output par_t pr);
        logic [3:0]  c [14];
        logic [15:0] gp;
        logic [3:0]  coef;
        gp = 16'hDC87;
        for (int i = 0; i < 14; i++) c[i] = '0;
        for (int b = 0; b < KB; b++) begin
            c[2*b]   = f[b][7:4];
            c[2*b+1] = f[b][3:0];
        end
        for (int i = 0; i < 10; i++) begin
            coef = c[i];
            for (int j = 1; j <= 4; j++)
                c[i+j] = c[i+j] ^ gmul(coef, gp[(4-j)*4 +: 4]);
        end
        for (int b = 0; b < PB; b++) pr[b] = {c[10+2*b], c[10+2*b+1]};
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall stability, ready under stall.
    always @(negedge clk) begin
        logic [9:0] exp;
        logic [9:0] got;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                assert (out_valid === 1'b1 && out_data === held) else begin
                    errors++;
                    $error("FAIL stall_hold got %b/%h exp 1/%h", out_valid, out_data, held);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                assert (in_ready === 1'b0) else begin
                    errors++;
                    $error("FAIL ready_in_stall got %b exp 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                got = {out_first, out_last, out_data};
                exp = (q.size() != 0) ? q.pop_front() : 10'bx;
                checks++;
                assert (got === exp) else begin
                    errors++;
                    $error("FAIL beat got %h exp %h", got, exp);
                end
                if (window) begin
                    if (nxfer == 0) firstc = cyc;
                    lastc = cyc;
                    nxfer++;
                end
            end
            if (window && !in_ready) irlow++;
            stall_prev = out_valid && !out_ready;
            held = out_data;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic en);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        enc_en = en;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_data", 32'(out_data), 32'(d));
    endtask

    task automatic send_frame(input frame_t f, input logic en);
        par_t pr;
        encode_ref(f, pr);
        for (int b = 0; b < KB; b++) begin
            q.push_back({b == 0, (!en && b == KB - 1), f[b]});
            send_beat(f[b], en);
        end
        if (en)
            for (int b = 0; b < PB; b++)
                q.push_back({1'b0, b == PB - 1, pr[b]});
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data = 8'bx;
        enc_en = 1'bx;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        frame_t zf;
        frame_t uf;
        frame_t bf;
        frame_t rf;
        par_t   pr;
        zf = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        uf = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        bf = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
        rf = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

        rst = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_first", 32'(out_first), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        encode_ref(uf, pr);
        chk("ref_unit_p0", 32'(pr[0]), 32'hDC);
        chk("ref_unit_p1", 32'(pr[1]), 32'h87);

        send_frame(zf, 1'b1);
        idle_in();
        drain("zero");

        send_frame(uf, 1'b1);
        idle_in();
        drain("unit");

        bp_mode = 1'b1;
        send_frame(uf, 1'b1);
        idle_in();
        drain("bp");
        bp_mode = 1'b0;

        send_frame(bf, 1'b0);
        idle_in();
        drain("bypass");
        send_frame(uf, 1'b1);
        idle_in();
        drain("after_bypass");

        @(posedge clk);
        #1;
        irlow = 0;
        nxfer = 0;
        window = 1'b1;
        send_frame(uf, 1'b1);
        send_frame(uf, 1'b1);
        idle_in();
        drain("b2b");
        window = 1'b0;
        chk("b2b_ready_low", 32'(irlow), 32'd4);
        chk("b2b_beats", 32'(nxfer), 32'd14);
        chk("b2b_span", 32'(lastc - firstc), 32'd13);

        bp_mode = 1'b1;
        send_frame(rf, 1'b1);
        idle_in();
        drain("mixed");
        bp_mode = 1'b0;

        for (int b = 0; b < 3; b++) begin
            q.push_back({b == 0, 1'b0, bf[b]});
            send_beat(bf[b], 1'b1);
        end
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        q.delete();
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(uf, 1'b1);
        idle_in();
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
